vga_frame_monitor: RTL

Synthesizable monitor that sits downstream of the racing-game video wrapper and consumes its `hsync`/`vsync`/`rgb` stream on the pixel-clock enable. It measures line and frame lengths against 800×525 timing, locks onto the raster, and counts lit pixels in the active window. Per frame it compresses the active-window pixels into a 16-bit signature. It reports a per-frame summary, so a bench or on-chip self-test can check video output without dumping images.

---
 rtl/vga_mon_pkg.sv | 13 +
 rtl/vga_sync_edge.sv | 29 ++
 rtl/vga_frame_monitor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/vga_mon_pkg.sv
// vga_mon_pkg: shared types, signature constants and signature step for the VGA frame monitor
package vga_mon_pkg;

    typedef enum logic [1:0] {SEEK, SYNC, LOCK} mon_state_t;

    localparam logic [15:0] SIG_POLY = 16'h1021;
    localparam logic [15:0] SIG_SEED = 16'hFFFF;

    function automatic logic [15:0] sig_next(input logic [15:0] sig, input logic [2:0] rgb);
        return {sig[14:0], 1'b0} ^ (sig[15] ? SIG_POLY : 16'h0000) ^ {13'b0, rgb};
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: pix_en-gated sampling and leading-edge detection of one sync signal
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   pix_en_i      : pixel strobe, the only cycles in which sync_i is sampled
//   sync_i        : sync input
//   edge_o        : high in a pix_en cycle whose sample is asserted and the previous one was not
module vga_sync_edge #(
    parameter logic SYNC_POL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pix_en_i,
    input  logic sync_i,
    output logic edge_o
);

    logic prev_q;

    // Resetting to the asserted level means a sync held asserted through
    // reset release is not mistaken for a fresh edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            prev_q <= SYNC_POL;
        else if (pix_en_i)
            prev_q <= sync_i;
    end

    assign edge_o = pix_en_i && sync_i == SYNC_POL && prev_q != SYNC_POL;

endmodule

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: raster timing check, lock FSM, lit-pixel count and per-frame signature
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   pix_en_i         : pixel strobe; all state advances only on it
//   hsync_i, vsync_i : sync inputs, asserted at SYNC_POL
//   rgb_i            : pixel colour
//   err_clr_i        : clears the sticky h_err_o / v_err_o
//   frame_done_o     : one-cycle pulse when a frame closes
//   frame_ok_o       : closed frame had no length error or counter saturation
//   frame_sig_o      : signature of the closed frame
//   lit_cnt_o        : active pixels with non-zero colour in the closed frame
//   frame_cnt_o      : closed frames, wrapping
//   locked_o         : FSM is in LOCK
//   h_err_o, v_err_o : sticky bad-line / bad-frame flags
module vga_frame_monitor
    import vga_mon_pkg::*;
#(
    parameter int   H_TOTAL  = 800,
    parameter int   V_TOTAL  = 525,
    parameter int   H_START  = 0,
    parameter int   V_START  = 0,
    parameter int   H_ACTIVE = 640,
    parameter int   V_ACTIVE = 480,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pix_en_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic [2:0]  rgb_i,
    input  logic        err_clr_i,
    output logic        frame_done_o,
    output logic        frame_ok_o,
    output logic [15:0] frame_sig_o,
    output logic [18:0] lit_cnt_o,
    output logic [15:0] frame_cnt_o,
    output logic        locked_o,
    output logic        h_err_o,
    output logic        v_err_o
);

    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 2);

    logic          hs_edge, vs_edge;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d, vlines;
    logic [15:0]   sig_q, sig_d, base_sig;
    logic [18:0]   lit_q, lit_d;
    logic          bad_line_q, bad_line_d, sat_q, sat_d;
    logic          line_bad, frame_bad, h_sat, v_sat, bad_now, active, frame_ok_d;
    logic          h_err_q, h_err_d, v_err_q, v_err_d;
    logic          done_q, ok_q, locked_q;
    logic [15:0]   fsig_q, fcnt_q;
    logic [18:0]   flit_q;
    mon_state_t    state_q, state_d;

    vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_hs (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .pix_en_i (pix_en_i),
        .sync_i   (hsync_i),
        .edge_o   (hs_edge)
    );

    vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_vs (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .pix_en_i (pix_en_i),
        .sync_i   (vsync_i),
        .edge_o   (vs_edge)
    );

    // The frame length counts the hsync edge that coincides with the closing
    // vsync edge, so a raster whose vsync edge lands on a line start measures
    // exactly V_TOTAL lines.
    always_comb begin
        line_bad   = hs_edge && hcnt_q != HW'(H_TOTAL - 1);
        vlines     = vcnt_q + VW'(hs_edge);
        frame_bad  = vs_edge && vlines != VW'(V_TOTAL);
        h_sat      = pix_en_i && !hs_edge && hcnt_q == HW'(H_TOTAL);
        v_sat      = hs_edge && !vs_edge && vcnt_q == VW'(V_TOTAL);
        hcnt_d     = hs_edge ? '0 : hcnt_q + HW'(!h_sat);
        vcnt_d     = vs_edge ? '0 : vcnt_q + VW'(hs_edge && !v_sat);
        active     = int'(hcnt_d) >= H_START && int'(hcnt_d) < H_START + H_ACTIVE &&
                     int'(vcnt_d) >= V_START && int'(vcnt_d) < V_START + V_ACTIVE;
        base_sig   = vs_edge ? SIG_SEED : sig_q;
        sig_d      = active ? sig_next(base_sig, rgb_i) : base_sig;
        lit_d      = (vs_edge ? '0 : lit_q) + 19'(active && rgb_i != 3'd0);
        // A bad line ending on the vsync edge belongs to the frame being closed.
        bad_line_d = !vs_edge && (bad_line_q || line_bad);
        sat_d      = !vs_edge && (sat_q || h_sat || v_sat);
        bad_now    = line_bad || frame_bad || h_sat || v_sat;
        frame_ok_d = !(bad_now || bad_line_q || sat_q);
        h_err_d    = (h_err_q && !err_clr_i) || (state_q != SEEK && line_bad);
        v_err_d    = (v_err_q && !err_clr_i) || (state_q != SEEK && frame_bad);
        state_d    = state_q == SEEK ? (vs_edge ? SYNC : SEEK) :
                     state_q == SYNC ? (vs_edge && frame_ok_d ? LOCK : SYNC) :
                     (bad_now ? SYNC : LOCK);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= SEEK;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            sig_q      <= '0;
            lit_q      <= '0;
            bad_line_q <= 1'b0;
            sat_q      <= 1'b0;
            h_err_q    <= 1'b0;
            v_err_q    <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            locked_q   <= 1'b0;
            fsig_q     <= '0;
            flit_q     <= '0;
            fcnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (pix_en_i) begin
                state_q    <= state_d;
                locked_q   <= state_d == LOCK;
                hcnt_q     <= hcnt_d;
                vcnt_q     <= vcnt_d;
                sig_q      <= sig_d;
                lit_q      <= lit_d;
                bad_line_q <= bad_line_d;
                sat_q      <= sat_d;
                h_err_q    <= h_err_d;
                v_err_q    <= v_err_d;
                if (vs_edge && state_q != SEEK) begin
                    done_q <= 1'b1;
                    ok_q   <= frame_ok_d;
                    fsig_q <= sig_q;
                    flit_q <= lit_q;
                    fcnt_q <= fcnt_q + 16'd1;
                end
            end
        end
    end

    assign frame_done_o = done_q;
    assign frame_ok_o   = ok_q;
    assign frame_sig_o  = fsig_q;
    assign lit_cnt_o    = flit_q;
    assign frame_cnt_o  = fcnt_q;
    assign locked_o     = locked_q;
    assign h_err_o      = h_err_q;
    assign v_err_o      = v_err_q;

endmodule
